// File: rtl/mult_sequencer.sv
// Control FSM for the shift-and-add multiplier: LOAD, n RUN steps, one-cycle DONE pulse.
// Optional MULT_EARLY_EXIT_EN: leave RUN as soon as the multiplier register reads zero.
module mult_sequencer #(
    parameter int n  = 8,
    parameter int CW = $clog2(n) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          mult_lsb,
    input  logic          mult_zero,
    output logic          sel_load,
    output logic          en_shift,
    output logic          acc_clear,
    output logic          acc_load,
    output logic          busy,
    output logic          finished,
    output logic [CW-1:0] count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        sel_load  = 1'b0;
        en_shift  = 1'b0;
        acc_clear = 1'b0;
        acc_load  = 1'b0;
        busy      = 1'b0;
        finished  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                sel_load  = 1'b1;
                en_shift  = 1'b1;
                acc_clear = 1'b1;
                busy      = 1'b1;
                count_d   = '0;
                state_d   = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                en_shift = 1'b1;
                acc_load = mult_lsb;
                count_d  = count_q + 1'b1;
                // Exit on the last iteration so count lands on n and never wraps.
                if (count_q == CW'(n - 1)) state_d = DONE;
`ifdef MULT_EARLY_EXIT_EN
                if (mult_zero) begin
                    en_shift = 1'b0;
                    acc_load = 1'b0;
                    count_d  = count_q;
                    state_d  = DONE;
                end
`endif
            end
            DONE: begin
                finished = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign count = count_q;

`ifndef MULT_EARLY_EXIT_EN
    logic unused_zero;
    assign unused_zero = mult_zero;
`endif

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: behavioural shift/add datapath driven by the FSM controls.
module tb_mult_sequencer;

    localparam int N  = 8;
    localparam int CW = $clog2(N) + 1;

    logic          clock = 1'b0;
    logic          reset, start, mult_lsb, mult_zero;
    logic          sel_load, en_shift, acc_clear, acc_load, busy, finished;
    logic [CW-1:0] count;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  op_a, op_b;
    logic [15:0] a_q;
    logic [7:0]  b_q;
    logic [15:0] acc_q;

    mult_sequencer #(.n(N), .CW(CW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .mult_lsb(mult_lsb), .mult_zero(mult_zero),
        .sel_load(sel_load), .en_shift(en_shift), .acc_clear(acc_clear),
        .acc_load(acc_load), .busy(busy), .finished(finished), .count(count)
    );

    always #5 clock = ~clock;

    initial begin
        a_q = '0; b_q = '0; acc_q = '0;
    end

    always @(posedge clock) begin
        if (en_shift) begin
            if (sel_load) begin
                a_q <= {8'd0, op_a};
                b_q <= op_b;
            end else begin
                a_q <= a_q << 1;
                b_q <= b_q >> 1;
            end
        end
        if (acc_clear)     acc_q <= '0;
        else if (acc_load) acc_q <= acc_q + a_q;
    end

    assign mult_lsb  = b_q[0];
    assign mult_zero = (b_q == 8'd0);

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        int          cnt;   // iterations performed (count at DONE)
        int          runs;  // RUN cycles before DONE
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Issue one operation from IDLE with a single start pulse and check every cycle.
    task automatic run_op(input vec_t v);
        op_a = v.a; op_b = v.b;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_busy", int'(busy), 1);
        chk("load_sel", int'(sel_load), 1);
        chk("load_clr", int'(acc_clear), 1);
        chk("load_shift", int'(en_shift), 1);
        for (int i = 0; i < v.runs; i++) begin
            tick();
            chk("run_busy", int'(busy), 1);
            chk("run_fin", int'(finished), 0);
            chk("run_shift", int'(en_shift), (i < v.cnt) ? 1 : 0);
            chk("run_accld", int'(acc_load), (i < v.cnt) ? int'(v.b[i]) : 0);
        end
        tick();
        chk("done_fin", int'(finished), 1);
        chk("done_busy", int'(busy), 0);
        chk("done_shift", int'(en_shift), 0);
        chk("done_count", int'(count), v.cnt);
        chk("product", int'(acc_q), int'(v.prod));
        tick();
        chk("idle_fin", int'(finished), 0);
        chk("idle_count", int'(count), v.cnt);
    endtask

    initial begin
`ifdef MULT_EARLY_EXIT_EN
        vecs[0] = '{8'd13,  8'd11,   16'd143,   4, 5};
        vecs[1] = '{8'd255, 8'd255,  16'd65025, 8, 8};
        vecs[2] = '{8'd7,   8'h80,   16'd896,   8, 8};
        vecs[3] = '{8'd200, 8'd0,    16'd0,     0, 1};
        vecs[4] = '{8'd9,   8'd5,    16'd45,    3, 4};
        vecs[5] = '{8'd25,  8'd10,   16'd250,   4, 5};
`else
        vecs[0] = '{8'd13,  8'd11,   16'd143,   8, 8};
        vecs[1] = '{8'd255, 8'd255,  16'd65025, 8, 8};
        vecs[2] = '{8'd7,   8'h80,   16'd896,   8, 8};
        vecs[3] = '{8'd200, 8'd0,    16'd0,     8, 8};
        vecs[4] = '{8'd9,   8'd5,    16'd45,    8, 8};
        vecs[5] = '{8'd25,  8'd10,   16'd250,   8, 8};
`endif
        reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("rst_outs", int'({sel_load, en_shift, acc_clear, acc_load, busy, finished}), 0);
            chk("rst_count", int'(count), 0);
            tick();
        end

        foreach (vecs[i]) run_op(vecs[i]);

        // start held high: one IDLE cycle between DONE and the next LOAD
        op_a = 8'd3; op_b = 8'hFF;
        start = 1'b1;
        tick();
        for (int op = 0; op < 3; op++) begin
            chk("b2b_load", int'(sel_load & busy), 1);
            for (int i = 0; i < N; i++) begin
                tick();
                chk("b2b_run", int'(busy), 1);
            end
            tick();
            chk("b2b_fin", int'(finished), 1);
            chk("b2b_count", int'(count), N);
            chk("b2b_prod", int'(acc_q), 765);
            tick();
            chk("b2b_idle", int'(busy | finished), 0);
            tick();
        end
        start = 1'b0;
        chk("b2b_last_load", int'(busy), 1);
        for (int i = 0; i < N + 2; i++) tick();
        chk("b2b_drain", int'(busy | finished), 0);

        // reset in RUN cycle 4 aborts with no finished pulse
        op_a = 8'd13; op_b = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("abort_inrun", int'(busy & ~sel_load), 1);
        chk("abort_cnt4", int'(count), 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_count", int'(count), 0);
        for (int i = 0; i < 10; i++) begin
            chk("abort_nofin", int'(finished | busy), 0);
            tick();
        end
        run_op(vecs[0]);

        // reset and start together: reset wins
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        chk("rs_busy", int'(busy), 0);
        chk("rs_sel", int'(sel_load), 0);
        tick();
        chk("rs_busy2", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
